// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring shift-subtract step of the sequential divider.
module div_step #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;

    // A borrow out of the widened subtraction means the trial failed, so restore.
    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {2'b00, divisor};
        q_bit   = ~diff[WIDTH+1];
        rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_EARLY_EXIT_EN to finish at once when DIVIDEND < DIVISOR.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             DIV_BY_ZERO
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic [WIDTH:0]   rem_reg;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [CW-1:0]    count;
    logic             zero_div;
    logic             early_exit;
    logic             last_step;

    assign zero_div  = (DIVISOR == '0);
    assign last_step = (count == LAST_STEP);

`ifdef SEQ_DIVIDER_EARLY_EXIT_EN
    assign early_exit = (DIVIDEND < DIVISOR);
`else
    assign early_exit = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_reg),
        .bit_in  (dvd_reg[WIDTH-1]),
        .divisor (dvs_reg),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        BUSY       = 1'b0;
        DONE       = 1'b0;
        case (state)
            IDLE: begin
                if (START) next_state = (zero_div || early_exit) ? FINISH : RUN;
            end
            RUN: begin
                BUSY = 1'b1;
                if (last_step) next_state = FINISH;
            end
            FINISH: begin
                DONE       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: each step shifts a dividend bit out and a quotient bit in.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dvd_reg     <= '0;
            dvs_reg     <= '0;
            rem_reg     <= '0;
            count       <= '0;
            QUOTIENT    <= '0;
            REMAINDER   <= '0;
            DIV_BY_ZERO <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        dvd_reg <= DIVIDEND;
                        dvs_reg <= DIVISOR;
                        rem_reg <= '0;
                        count   <= '0;
                        if (zero_div) begin
                            QUOTIENT    <= '1;
                            REMAINDER   <= DIVIDEND;
                            DIV_BY_ZERO <= 1'b1;
                        end else if (early_exit) begin
                            QUOTIENT    <= '0;
                            REMAINDER   <= DIVIDEND;
                            DIV_BY_ZERO <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
                    count   <= count + 1'b1;
                    if (last_step) begin
                        QUOTIENT    <= {dvd_reg[WIDTH-2:0], q_bit};
                        REMAINDER   <= rem_next[WIDTH-1:0];
                        DIV_BY_ZERO <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
